// File: rtl/tick_pkg.sv
// Shared types and default widths for the tick counter and its prescaler.
package tick_pkg;

    typedef enum logic {TICK_PERIODIC = 1'b0, TICK_ONESHOT = 1'b1} tick_mode_t;

    localparam int TICK_N_DEF = 26;
    localparam int TICK_P_DEF = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Enabled-cycle divider: strobes once every presc+1 enabled cycles.
module tick_prescaler #(
    parameter int P = 8
) (
    input  logic         boardClk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [P-1:0] presc,
    output logic         strobe
);

    logic [P-1:0] cnt;

    // Equality compare: a presc change simply applies at the next compare.
    assign strobe = en && (cnt == presc);

    always_ff @(posedge boardClk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= strobe ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/tick_counter.sv
// Programmable-modulus up/down counter with terminal tick and one-shot mode.
// Optional prescaler compiled in with TICK_COUNTER_PRESCALE_EN.
module tick_counter
    import tick_pkg::*;
#(
    parameter int N = TICK_N_DEF,
    parameter int P = TICK_P_DEF
) (
    input  logic         boardClk,
    input  logic         rst,
    input  logic         en,
    input  logic         UpDownn,
    input  logic         oneShot,
    input  logic         load,
    input  logic [N-1:0] loadVal,
    input  logic [N-1:0] modulus,
`ifdef TICK_COUNTER_PRESCALE_EN
    input  logic [P-1:0] presc,
`endif
    output logic [N-1:0] count,
    output logic         tic,
    output logic         done
);

    logic       strobe;
    logic       step;
    logic       terminal;
    tick_mode_t mode;

`ifdef TICK_COUNTER_PRESCALE_EN
    tick_prescaler #(.P(P)) u_presc (
        .boardClk (boardClk),
        .rst      (rst),
        .en       (en),
        .clr      (load),
        .presc    (presc),
        .strobe   (strobe)
    );
`else
    assign strobe = 1'b1;
`endif

    assign step = en && strobe;
    assign mode = oneShot ? TICK_ONESHOT : TICK_PERIODIC;

    always_comb begin
        terminal = 1'b0;
        if (UpDownn) terminal = (count == modulus);
        else         terminal = (count == '0);
    end

    always_ff @(posedge boardClk) begin
        if (rst) begin
            count <= '0;
            tic   <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            count <= loadVal;
            tic   <= 1'b0;
            done  <= 1'b0;
        end else if (step && !done) begin
            tic <= terminal;
            if (terminal) begin
                // One-shot holds at the terminal value until reloaded.
                if (mode == TICK_ONESHOT) done  <= 1'b1;
                else                      count <= UpDownn ? '0 : modulus;
            end else begin
                count <= UpDownn ? count + 1'b1 : count - 1'b1;
            end
        end else begin
            tic <= 1'b0;
        end
    end

endmodule

// File: doc/tick_counter.md
# tick_counter

Parametrised programmable-modulus up/down counter with terminal-count tick, synchronous load and periodic/one-shot modes. It generates the periodic timing strobes used by the display, debounce and LED blocks, all running from the single board clock. It replaces fixed-width free-running counters wherever a tick period must be set at run time.

## Interface
- N, 26, counter width in bits
- P, 8, prescaler width in bits; used only when the prescaler is compiled in
- boardClk  input  1  system clock; all logic is on its rising edge
- rst  input  1  reset, synchronous and active-high
- en  input  1  count enable; when low, the counter and prescaler hold
- UpDownn  input  1  direction: 1 = up, 0 = down
- oneShot  input  1  mode: 0 = periodic wrap, 1 = one-shot (stop at terminal)
- load  input  1  synchronous load strobe
- loadVal  input  N  value to load
- modulus  input  N  terminal value; the period is modulus+1 steps
- presc  input  P  prescale divisor minus 1; present only with TICK_COUNTER_PRESCALE_EN
- count  output  N  current counter value
- tic  output  1  registered one-cycle terminal-count pulse
- done  output  1  one-shot finished flag

## Operation
- step = en & prescaler strobe. Without the prescaler, step = en.
- Priority per edge: rst > load > step > hold.
- load: count <= loadVal, done <= 0, prescaler cleared, tic <= 0. A load overrides a simultaneous step.
- Up step:
  - count==modulus → terminal event: count <= 0 in periodic mode, hold in one-shot mode.
  - Otherwise count <= count+1, modulo 2^N.
- Down step:
  - count==0 → terminal event: count <= modulus in periodic mode, hold in one-shot mode.
  - Otherwise count <= count-1.
- Terminal event:
  - tic is 1 on the following cycle only.
  - In one-shot mode, done <= 1.
- While done=1: steps are ignored, count holds, tic stays 0. Only load or rst clears done.
- The terminal compare is equality only.
  - If loadVal > modulus counting up: the count runs to 2^N-1, rolls to 0 with no tic, then continues to modulus.
- modulus=0 counting up: every step is a terminal event, so count stays 0 and tic fires once per step.
- modulus, UpDownn and oneShot are sampled on every edge. A change mid-period takes effect at the next step with no restart.
- Clearing oneShot while done=1 does not restart counting; a load is required.

## Timing
- Reset values: count=0, tic=0, done=0, prescaler=0.
- Latency: count updates on the edge where step=1. tic and done are registered and assert on the same edge as the terminal transition, visible for that cycle only (tic).
- Periodic, en held high, no prescale: tic period = modulus+1 cycles, one cycle wide.
- Reset asserted mid-period or mid-pulse: everything returns to reset values on that edge, and tic drops immediately.
- The outputs have no combinational path from any input.

## Configuration
- Macro: TICK_COUNTER_PRESCALE_EN.
- Defined:
  - Adds the presc port and a P-bit prescaler.
  - The prescaler counts enabled cycles 0..presc and asserts its strobe when it reaches presc, then wraps to 0. step occurs every presc+1 enabled cycles.
  - presc=0 gives a step on every enabled cycle.
  - The prescaler freezes when en=0 and clears on rst or load.
  - A presc change takes effect on the next compare.
- Not defined: there is no presc port, no prescaler logic, and step = en.

## Structure
- Shared package tick_pkg:
  - typedef enum tick_mode_t {TICK_PERIODIC, TICK_ONESHOT}
  - Default width constants TICK_N_DEF=26 and TICK_P_DEF=8
- One sub-module, tick_prescaler: inputs boardClk, rst, en, clr, presc; output strobe.
  - It is instantiated only under TICK_COUNTER_PRESCALE_EN.

## Test plan
- N=8, modulus=4, up, periodic, en=1 from reset → count 0,1,2,3,4,0… and tic high one cycle after each 4→0, period 5.
- Down, modulus=3, load 2 → count 2,1,0,3,2… and tic one cycle after each 0→3.
- One-shot, up, modulus=2 → count 0,1,2 then holds at 2. tic pulses once, done=1 stays high, and the next load of 0 clears done.
- Load 250 with modulus=4 (N=8), up → count 250…255, 0 (no tic), 1…4, then tic. Also, load and step in the same cycle → loadVal wins.
- With TICK_COUNTER_PRESCALE_EN, presc=2, modulus=1 → count advances every 3 cycles and tic every 6. Dropping en for 2 cycles extends that gap by exactly 2.
- rst asserted in the cycle tic=1 → next cycle count=0, tic=0, done=0.
